run_sequencer: RTL and testbench

- Sits directly downstream of the bench clock/reset generator and upstream of the compiler DUT.
- Consumes the raw `clk`/`reset` pair and produces a staged reset release (`rst_out`) and a one-cycle `start` pulse for the DUT.
- Counts cycles from `start` until the DUT raises `done`. If `done` never arrives, it flags a watchdog timeout.
- Gives the bench one place to read pass/fail/latency status.

---
 rtl/run_sequencer.sv | 122 ++++++++++++
 tb/tb_run_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// Test-run sequencer: staged DUT reset release, one-shot start pulse,
// and a cycle counter with watchdog that latches the completion status.
module run_sequencer #(
    parameter int RST_HOLD    = 4,
    parameter int START_DELAY = 2,
    parameter int TIMEOUT     = 1000,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             done,
    output logic             rst_out,
    output logic             start,
    output logic             busy,
    output logic             finished,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        HOLD,
        WAIT,
        RUN,
        DONE,
        TOUT
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(START_DELAY - 1);
    localparam logic [CNT_W-1:0] TOUT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TOUT_VALUE = CNT_W'(TIMEOUT);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] cycle_count_reg, cycle_count_next;
    logic             rst_out_reg, rst_out_next;
    logic             start_reg, start_next;
    logic             busy_reg, busy_next;
    logic             finished_reg, finished_next;
    logic             timeout_reg, timeout_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= HOLD;
            cnt_reg         <= '0;
            cycle_count_reg <= '0;
            rst_out_reg     <= 1'b1;
            start_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            finished_reg    <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            cycle_count_reg <= cycle_count_next;
            rst_out_reg     <= rst_out_next;
            start_reg       <= start_next;
            busy_reg        <= busy_next;
            finished_reg    <= finished_next;
            timeout_reg     <= timeout_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        cycle_count_next = cycle_count_reg;
        rst_out_next     = rst_out_reg;
        start_next       = 1'b0;  // start can only ever last one cycle
        busy_next        = busy_reg;
        finished_next    = finished_reg;
        timeout_next     = timeout_reg;

        case (state_reg)
            HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next   = WAIT;
                    rst_out_next = 1'b0;
                    cnt_next     = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            WAIT: begin
                if (cnt_reg == WAIT_LAST) begin
                    state_next       = RUN;
                    start_next       = 1'b1;
                    busy_next        = 1'b1;
                    cycle_count_next = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RUN: begin
                // done is checked first so it beats a coincident watchdog expiry
                if (done) begin
                    state_next    = DONE;
                    finished_next = 1'b1;
                    busy_next     = 1'b0;
                end else if (cycle_count_reg == TOUT_LAST) begin
                    state_next       = TOUT;
                    timeout_next     = 1'b1;
                    busy_next        = 1'b0;
                    cycle_count_next = TOUT_VALUE;
                end else begin
                    cycle_count_next = cycle_count_reg + 1'b1;
                end
            end
            default: begin
                state_next = state_reg;
            end
        endcase
    end

    assign rst_out     = rst_out_reg;
    assign start       = start_reg;
    assign busy        = busy_reg;
    assign finished    = finished_reg;
    assign timeout     = timeout_reg;
    assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: directed test-plan scenarios plus random runs,
// checked every cycle against a timeline model keyed on edges since reset fell.
module tb_run_sequencer;

    localparam int R     = 4;
    localparam int S     = 2;
    localparam int T     = 5;
    localparam int CNT_W = 32;
    localparam int RS    = R + S;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             done = 1'b0;
    logic             rst_out, start, busy, finished, timeout;
    logic [CNT_W-1:0] cycle_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: edges with reset low since the last reset edge,
    // terminal outcome (0 none, 1 finished, 2 timeout) and its latched count.
    int k = 0;
    int term = 0;
    int fcnt = 0;

    run_sequencer #(
        .RST_HOLD(R),
        .START_DELAY(S),
        .TIMEOUT(T),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .done(done),
        .rst_out(rst_out),
        .start(start),
        .busy(busy),
        .finished(finished),
        .timeout(timeout),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit d);
        int j;
        if (r) begin
            k = 0;
            term = 0;
            fcnt = 0;
        end else begin
            if (k < 100000) k++;
            if (term == 0 && k > RS) begin
                j = k - RS;  // j-th RUN edge; count before it is j-1
                if (d) begin
                    term = 1;
                    fcnt = j - 1;
                end else if (j == T) begin
                    term = 2;
                    fcnt = T;
                end
            end
        end
    endtask

    task automatic check_outputs();
        int exp_cc;
        exp_cc = (term != 0) ? fcnt : ((k > RS) ? k - RS : 0);
        chk("rst_out", 32'(rst_out), 32'(k < R));
        chk("start", 32'(start), 32'(k == RS));
        chk("busy", 32'(busy), 32'(term == 0 && k >= RS));
        chk("finished", 32'(finished), 32'(term == 1));
        chk("timeout", 32'(timeout), 32'(term == 2));
        chk("cycle_count", cycle_count, 32'(exp_cc));
    endtask

    // mode 0: done steps high once the edge index reaches done_at; mode 1: random done.
    task automatic run_scenario(input string name, input int rlen, input int len,
                                input int mode, input int done_at, input int pulse);
        int err0;
        err0 = n_err;
        for (int c = 0; c < len; c++) begin
            reset = (c < rlen) || (c == pulse);
            if (mode != 0) done = ($urandom_range(0, 3) == 0);
            else           done = !reset && (k + 1 >= done_at);
            @(posedge clk);
            model_edge(reset, done);
            #1;
            check_outputs();
        end
        $display("scenario %s: rlen=%0d len=%0d mode=%0d done_at=%0d pulse=%0d end: fin=%0b tout=%0b cc=%0d errors=%0d",
                 name, rlen, len, mode, done_at, pulse, finished, timeout, cycle_count, n_err - err0);
    endtask

    initial begin
        reset = 1'b1;
        done  = 1'b0;
        // Directed cases from the test plan
        run_scenario("done_at_E10", 2, 40, 0, 10, -1);
        run_scenario("watchdog", 2, 30, 0, 999, -1);
        run_scenario("coincident", 2, 25, 0, 11, -1);
        run_scenario("done_early", 2, 20, 0, 1, -1);
        run_scenario("mid_run_reset", 2, 35, 0, 10, 9);
        // Randomized runs
        for (int i = 0; i < 40; i++) begin
            int rlen, len, mode, dat, pulse;
            rlen  = $urandom_range(1, 3);
            len   = rlen + $urandom_range(8, 24);
            mode  = $urandom_range(0, 1);
            dat   = ($urandom_range(0, 4) == 0) ? 999 : $urandom_range(1, 14);
            pulse = ($urandom_range(0, 1) == 1) ? $urandom_range(rlen, len - 1) : -1;
            run_scenario("random", rlen, len, mode, dat, pulse);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
